fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: owns the PC, issues word reads to instruction memory and
//  buffers returned words in an in-order FIFO. Drives id_valid/instr into the decode
//  stage (control_unit) with an id_ready backpressure handshake. Branch/jump redirects
//  from later stages flush the FIFO and discard all in-flight responses.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC of the first fetch after reset; bits [1:0] must be 0
//  FIFO_DEPTH   2              instruction buffer entries (power of 2, >=2)
//  MAX_OUTST    2              max outstanding imem requests (<= FIFO_DEPTH)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  fetch_en        in   1   1 = may issue new requests; 0 = hold PC, drain only
//  imem_req_valid  out  1   request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned byte address (= pc)
//  imem_rsp_valid  in   1   read data valid; responses return in request order
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   branch/jump taken; flush and refetch
//  redirect_pc     in   32  new PC; bits [1:0] forced to 0 internally
//  id_valid        out  1   FIFO head holds a valid instruction
//  id_ready        in   1   decode consumes head this cycle
//  instr           out  32  FIFO head instruction word
//  id_pc           out  32  PC of FIFO head instruction
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, FIFO empty, outst=0, drop=0, state=BOOT; outputs
//    imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, instr=0, id_pc=0.
//  - FSM: BOOT -> RUN unconditionally on first clock after reset release (no request in
//    BOOT). RUN is the only operating state; no other transitions.
//  - Request: imem_req_valid = RUN & fetch_en & ~redirect_valid & (outst < MAX_OUTST)
//    & (outst + count < FIFO_DEPTH). Credit rule guarantees every response has a slot;
//    no response is ever back-pressured. Handshake = valid & ready -> pc += 4, outst++.
//  - imem_req_valid/addr stay stable while ready=0 unless redirect_valid asserts.
//  - Response: imem_rsp_valid -> outst--; if drop>0 then drop-- and data discarded,
//    else {data, pc_of_request} pushed. Request PCs held in a MAX_OUTST-deep tag queue.
//  - Pop: id_valid & id_ready -> head removed. Push and pop in same cycle: count unchanged.
//  - Data written to FIFO visible on id_valid next cycle (1-cycle rsp->decode latency);
//    min latency req handshake -> id_valid = mem latency + 1.
//  - Redirect (priority over everything in that cycle): FIFO cleared (same-cycle pop
//    ignored), pc <= {redirect_pc[31:2],2'b00}, drop <= outst_next (outstanding count
//    after this cycle's response, i.e. all in-flight requests), no request issued.
//    A response arriving in the redirect cycle is discarded.
//  - id_valid=0 whenever FIFO empty; instr/id_pc hold last head value (not X).
//  - fetch_en=0: no new requests; outstanding responses still accepted; FIFO pops normal.
//  - pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//  - Reset mid-operation: all state cleared immediately; late responses after reset
//    release are not tracked (memory must be reset together).
//  - count/outst never exceed FIFO_DEPTH/MAX_OUTST; assertion fires on rsp with outst=0.
// TESTING
//  1 Reset, mem ready=1, 1-cycle latency -> first req addr 0x0 at cycle 2, id_pc 0,4,8..
//    back-to-back, id_valid held with id_ready=1.
//  2 id_ready=0 from start -> exactly FIFO_DEPTH requests issued (0x0,0x4), req_valid
//    then 0; release id_ready -> instrs in order, fetch resumes at 0x8.
//  3 2 requests in flight, redirect_valid to 0x103 -> both responses dropped, next
//    req addr 0x100, first id_pc after redirect = 0x100.
//  4 Redirect same cycle as rsp_valid and id_ready pop -> FIFO empty next cycle,
//    rsp data never appears on instr.
//  5 imem_req_ready=0 for 5 cycles -> addr/valid stable, pc unchanged; fetch_en=0 ->
//    req_valid=0 within 0 cycles, pending rsp still delivered.
//  6 Assert rst mid-stream -> id_valid, imem_req_valid 0 asynchronously; refetch 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads to imem,
// tags them in order and buffers returned words toward decode; redirects flush.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MAX_OUTST  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] instr,
   output logic [31:0] id_pc
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TAG_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned OST_W = $clog2(MAX_OUTST + 1);
   localparam int unsigned SUM_W = CNT_W + OST_W;

   localparam logic STATE_BOOT = 1'b0;
   localparam logic STATE_RUN  = 1'b1;

   logic              state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [OST_W-1:0]  outst_q, outst_d;
   logic [OST_W-1:0]  drop_q, drop_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [TAG_W-1:0]  tag_wr_ptr_q, tag_wr_ptr_d;
   logic [TAG_W-1:0]  tag_rd_ptr_q, tag_rd_ptr_d;
   logic [31:0]       last_instr_q, last_instr_d;
   logic [31:0]       last_pc_q, last_pc_d;

   logic [31:0]       fifo_instr_q [FIFO_DEPTH];
   logic [31:0]       fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]       tag_q        [MAX_OUTST];

   logic              run_c;
   logic              req_fire_c;
   logic              rsp_drop_c;
   logic              push_c;
   logic              pop_c;
   logic              unused_pc_lsb;

   assign unused_pc_lsb = ^redirect_pc[1:0];

   // Next-state, handshake and output logic
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      count_d      = count_q;
      drop_d       = drop_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      tag_wr_ptr_d = tag_wr_ptr_q;
      tag_rd_ptr_d = tag_rd_ptr_q;

      case (state_q)
         STATE_BOOT: state_d = STATE_RUN;
         default:    state_d = STATE_RUN;
      endcase

      run_c = (state_q == STATE_RUN);
      // Credit rule: every outstanding request already owns a buffer slot
      imem_req_valid = run_c && fetch_en && !redirect_valid
                    && (outst_q < OST_W'(MAX_OUTST))
                    && ((SUM_W'(outst_q) + SUM_W'(count_q)) < SUM_W'(FIFO_DEPTH));
      imem_req_addr  = pc_q;
      req_fire_c     = imem_req_valid && imem_req_ready;

      id_valid = (count_q != '0);
      instr    = id_valid ? fifo_instr_q[rd_ptr_q] : last_instr_q;
      id_pc    = id_valid ? fifo_pc_q[rd_ptr_q]    : last_pc_q;
      last_instr_d = instr;
      last_pc_d    = id_pc;

      rsp_drop_c = imem_rsp_valid && (drop_q != '0);
      push_c     = imem_rsp_valid && !rsp_drop_c && !redirect_valid;
      pop_c      = id_valid && id_ready && !redirect_valid;

      outst_d = outst_q + OST_W'(req_fire_c) - OST_W'(imem_rsp_valid);

      if (req_fire_c) begin
         tag_wr_ptr_d = (tag_wr_ptr_q == TAG_W'(MAX_OUTST - 1)) ? '0 : tag_wr_ptr_q + TAG_W'(1);
      end
      if (imem_rsp_valid) begin
         tag_rd_ptr_d = (tag_rd_ptr_q == TAG_W'(MAX_OUTST - 1)) ? '0 : tag_rd_ptr_q + TAG_W'(1);
      end

      if (redirect_valid) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         // Every request still in flight belongs to the abandoned path
         drop_d   = outst_d;
      end else begin
         if (req_fire_c) pc_d = pc_q + 32'd4;
         if (rsp_drop_c) drop_d = drop_q - OST_W'(1);
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= STATE_BOOT;
         pc_q         <= RESET_PC;
         count_q      <= '0;
         outst_q      <= '0;
         drop_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         tag_wr_ptr_q <= '0;
         tag_rd_ptr_q <= '0;
         last_instr_q <= '0;
         last_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         count_q      <= count_d;
         outst_q      <= outst_d;
         drop_q       <= drop_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tag_wr_ptr_q <= tag_wr_ptr_d;
         tag_rd_ptr_q <= tag_rd_ptr_d;
         last_instr_q <= last_instr_d;
         last_pc_q    <= last_pc_d;
      end
   end

   // Buffer and request-tag storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr_q[i] <= '0;
            fifo_pc_q[i]    <= '0;
         end
         for (int unsigned i = 0; i < MAX_OUTST; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         if (push_c) begin
            fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q]    <= tag_q[tag_rd_ptr_q];
         end
         if (req_fire_c) begin
            tag_q[tag_wr_ptr_q] <= pc_q;
         end
      end
   end

   a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model plus a scoreboard of
// expected {instr, pc} pushed on each request handshake and popped at decode.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] instr;
   logic [31:0] id_pc;

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2),
      .MAX_OUTST  (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .instr          (instr),
      .id_pc          (id_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] addr; int unsigned due; } mem_req_t;
   typedef struct packed { logic [31:0] instr; logic [31:0] pc; } exp_t;

   mem_req_t    mem_q[$];
   exp_t        exp_q[$];
   int unsigned cyc;
   int unsigned lat;
   int unsigned n_tests;
   int unsigned n_fail;
   int unsigned n_fire;
   logic [31:0] exp_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive memory response, sample mid-cycle, advance to posedge+1
   task automatic step();
      exp_t e;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #4;
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (redirect_valid) begin
         exp_q.delete();
         exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (id_valid && id_ready) begin
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_underflow: observed pc %h expected no instruction", id_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_instr", instr, e.instr);
            chk("sb_pc", id_pc, e.pc);
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         chk("req_addr", imem_req_addr, exp_pc);
         mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
         exp_q.push_back('{instr: mem_word(exp_pc), pc: exp_pc});
         exp_pc = exp_pc + 32'd4;
         n_fire++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      mem_q.delete();
      exp_q.delete();
      exp_pc = 32'h0;
      n_fire = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_id_valid(input string tag);
      int unsigned n;
      n = 0;
      while (!id_valid && n < 50) begin
         step();
         n++;
      end
      n_tests++;
      assert (id_valid === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed id_valid timeout after %0d cycles expected id_valid 1", tag, n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0; n_fire = 0; cyc = 0; lat = 1; exp_pc = 32'h0;
      rst = 1'b1; fetch_en = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      #2;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr",  imem_req_addr,       32'h0);
      chk("rst_id_valid",  32'(id_valid),       32'd0);
      chk("rst_instr",     instr,               32'h0);
      chk("rst_id_pc",     id_pc,               32'h0);

      // Streaming fetch with 1-cycle memory
      do_reset();
      chk("t1_boot_no_req", 32'(imem_req_valid), 32'd0);
      step();
      chk("t1_first_req", 32'(imem_req_valid), 32'd1);
      chk("t1_first_addr", imem_req_addr, 32'h0);
      repeat (20) step();

      // PC wrap through redirect near the top of the address space
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
      step();
      redirect_valid = 1'b0;
      wait_id_valid("t7_wait");
      chk("t7_wrap_first_pc", id_pc, 32'hFFFF_FFF8);
      repeat (12) step();

      // Decode stalled from the start: only FIFO_DEPTH requests
      id_ready = 1'b0;
      do_reset();
      repeat (10) step();
      chk("t2_fire_count", n_fire, 32'd2);
      chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
      chk("t2_id_valid", 32'(id_valid), 32'd1);
      id_ready = 1'b1;
      repeat (10) step();
      chk("t2_resumed", 32'(n_fire >= 3), 32'd1);

      // Redirect with two requests in flight
      lat = 3;
      do_reset();
      step();
      step();
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      step();
      redirect_valid = 1'b0;
      wait_id_valid("t3_wait");
      chk("t3_first_pc", id_pc, 32'h0000_0100);
      chk("t3_first_instr", instr, mem_word(32'h0000_0100));
      repeat (6) step();

      // Redirect coinciding with a response and a pop
      lat = 1;
      id_ready = 1'b0;
      do_reset();
      step();
      step();
      step();
      chk("t4_pre_valid", 32'(id_valid), 32'd1);
      id_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      step();
      redirect_valid = 1'b0;
      chk("t4_flushed", 32'(id_valid), 32'd0);
      wait_id_valid("t4_wait");
      chk("t4_first_pc", id_pc, 32'h0000_0200);
      chk("t4_first_instr", instr, mem_word(32'h0000_0200));
      repeat (6) step();

      // Memory not ready, then fetch disabled with a response pending
      imem_req_ready = 1'b0;
      do_reset();
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_valid", 32'(imem_req_valid), 32'd1);
         chk("t5_hold_addr", imem_req_addr, 32'h0);
         step();
      end
      chk("t5_no_fire", n_fire, 32'd0);
      imem_req_ready = 1'b1;
      step();
      fetch_en = 1'b0;
      #1;
      chk("t5_fetch_off", 32'(imem_req_valid), 32'd0);
      step();
      chk("t5_pending_valid", 32'(id_valid), 32'd1);
      chk("t5_pending_pc", id_pc, 32'h0);
      repeat (4) step();
      chk("t5_fire_frozen", n_fire, 32'd1);
      fetch_en = 1'b1;

      // Asynchronous reset in the middle of a stream
      do_reset();
      repeat (6) step();
      id_ready = 1'b0;
      wait_id_valid("t6_wait");
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_id_valid", 32'(id_valid), 32'd0);
      chk("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
      chk("t6_async_instr", instr, 32'h0);
      id_ready = 1'b1;
      do_reset();
      step();
      chk("t6_refetch_valid", 32'(imem_req_valid), 32'd1);
      chk("t6_refetch_addr", imem_req_addr, 32'h0);
      repeat (8) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
